// File: rtl/cache_controller_if.sv
// Shared size type and the bundled bus between the cache controller and its
// environment (core request/response, backing memory, external data array).
//
// Modports:
//   master - the environment: drives requests, memory replies and the data
//            array read word; observes everything the controller drives.
//   slave  - the cache controller itself.
//
// Signals:
//   req_valid/req_ready/req_addr/req_we/req_size/req_wdata - core request
//   resp_valid/resp_rdata                                  - core response
//   mem_valid/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  - backing memory
//   dl_perform_write/dl_set/dl_op_size/dl_word_select/
//   dl_byte_select/dl_word_to_store/dl_fetched_word        - data array port

package cache_controller_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_operation_size_e;
endpackage

interface cache_controller_if #(
    parameter int XLEN             = 32,
    parameter int SET_SIZE         = 2,
    parameter int WORD_SELECT_SIZE = 3,
    parameter int BYTE_SELECT_SIZE = 2
);
    import cache_controller_pkg::*;

    logic                        req_valid;
    logic                        req_ready;
    logic [XLEN-1:0]             req_addr;
    logic                        req_we;
    memory_operation_size_e      req_size;
    logic [XLEN-1:0]             req_wdata;
    logic                        resp_valid;
    logic [XLEN-1:0]             resp_rdata;

    logic                        mem_valid;
    logic                        mem_we;
    logic [XLEN-1:0]             mem_addr;
    logic [XLEN-1:0]             mem_wdata;
    logic                        mem_ack;
    logic [XLEN-1:0]             mem_rdata;

    logic                        dl_perform_write;
    logic [SET_SIZE-1:0]         dl_set;
    memory_operation_size_e      dl_op_size;
    logic [WORD_SELECT_SIZE-1:0] dl_word_select;
    logic [BYTE_SELECT_SIZE-1:0] dl_byte_select;
    logic [XLEN-1:0]             dl_word_to_store;
    logic [XLEN-1:0]             dl_fetched_word;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_wdata,
        output mem_ack, mem_rdata, dl_fetched_word,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        input  dl_perform_write, dl_set, dl_op_size, dl_word_select,
        input  dl_byte_select, dl_word_to_store
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_wdata,
        input  mem_ack, mem_rdata, dl_fetched_word,
        output req_ready, resp_valid, resp_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        output dl_perform_write, dl_set, dl_op_size, dl_word_select,
        output dl_byte_select, dl_word_to_store
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller. Holds tag,
// valid and dirty state per line; the line data lives in an external data
// array driven through the dl_* port. One request is in flight at a time.
//
// Ports:
//   clk     - single clock, all state on posedge
//   reset_n - asynchronous active-low reset (control state only)
//   bus     - cache_controller_if.slave: core request/response, backing
//             memory handshake and data-array control

module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int NUM_SETS         = 4,
    parameter int SET_SIZE         = 2,
    parameter int WORDS_PER_LINE   = 8,
    parameter int WORD_SELECT_SIZE = 3,
    parameter int BYTE_SELECT_SIZE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    cache_controller_if.slave bus
);

    localparam int TAG_W = XLEN - SET_SIZE - WORD_SELECT_SIZE - BYTE_SELECT_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        RESPOND
    } state_e;

    state_e                      state;
    logic [WORD_SELECT_SIZE-1:0] word_cnt;
    logic [NUM_SETS-1:0]         valid_q;
    logic [NUM_SETS-1:0]         dirty_q;
    logic [TAG_W-1:0]            tag_q [NUM_SETS];

    logic                        req_ready_q;
    logic                        resp_valid_q;
    logic [XLEN-1:0]             resp_rdata_q;

    logic [XLEN-1:0]             req_addr_q;
    logic                        req_we_q;
    memory_operation_size_e      req_size_q;
    logic [XLEN-1:0]             req_wdata_q;

    logic [TAG_W-1:0]            req_tag;
    logic [SET_SIZE-1:0]         req_set;
    logic [WORD_SELECT_SIZE-1:0] req_word;
    logic [BYTE_SELECT_SIZE-1:0] req_byte;

    logic                        accept;
    logic                        hit;
    logic                        last_beat;
    logic                        fill_done;

    logic                        mem_valid;
    logic                        mem_we;
    logic [XLEN-1:0]             mem_addr;
    logic [XLEN-1:0]             mem_wdata;
    logic                        dl_perform_write;
    logic [SET_SIZE-1:0]         dl_set;
    memory_operation_size_e      dl_op_size;
    logic [WORD_SELECT_SIZE-1:0] dl_word_select;
    logic [BYTE_SELECT_SIZE-1:0] dl_byte_select;
    logic [XLEN-1:0]             dl_word_to_store;

    // Address fields of the latched request: {tag, set, word, byte}
    assign req_byte = req_addr_q[BYTE_SELECT_SIZE-1:0];
    assign req_word = req_addr_q[BYTE_SELECT_SIZE +: WORD_SELECT_SIZE];
    assign req_set  = req_addr_q[BYTE_SELECT_SIZE+WORD_SELECT_SIZE +: SET_SIZE];
    assign req_tag  = req_addr_q[XLEN-1 -: TAG_W];

    assign accept    = (state == IDLE) && req_ready_q && bus.req_valid;
    assign hit       = valid_q[req_set] && (tag_q[req_set] == req_tag);
    assign last_beat = (word_cnt == WORD_SELECT_SIZE'(WORDS_PER_LINE - 1));
    assign fill_done = (state == FILL) && bus.mem_ack && last_beat;

    // Memory and data-array controls are decoded from the state register and
    // the beat counter, so they hold steady across a stalled beat and vanish
    // the moment reset forces the state back to IDLE.
    always_comb begin
        mem_valid        = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        dl_perform_write = 1'b0;
        dl_set           = req_set;
        dl_op_size       = req_size_q;
        dl_word_select   = req_word;
        dl_byte_select   = req_byte;
        dl_word_to_store = req_wdata_q;
        case (state)
            LOOKUP: begin
                dl_perform_write = hit && req_we_q;
            end
            WRITEBACK: begin
                mem_valid      = 1'b1;
                mem_we         = 1'b1;
                mem_addr       = {tag_q[req_set], req_set, word_cnt,
                                  {BYTE_SELECT_SIZE{1'b0}}};
                mem_wdata      = bus.dl_fetched_word;
                dl_op_size     = WORD;
                dl_word_select = word_cnt;
                dl_byte_select = '0;
            end
            FILL: begin
                mem_valid        = 1'b1;
                mem_addr         = {req_tag, req_set, word_cnt,
                                    {BYTE_SELECT_SIZE{1'b0}}};
                dl_op_size       = WORD;
                dl_word_select   = word_cnt;
                dl_byte_select   = '0;
                dl_word_to_store = bus.mem_rdata;
                dl_perform_write = bus.mem_ack;
            end
            default: begin
            end
        endcase
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            word_cnt     <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        state       <= LOOKUP;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                LOOKUP: begin
                    word_cnt <= '0;
                    if (hit) begin
                        resp_rdata_q <= req_we_q ? '0 : bus.dl_fetched_word;
                        if (req_we_q) begin
                            dirty_q[req_set] <= 1'b1;
                        end
                        resp_valid_q <= 1'b1;
                        state        <= RESPOND;
                    end else if (valid_q[req_set] && dirty_q[req_set]) begin
                        state <= WRITEBACK;
                    end else begin
                        state <= FILL;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack) begin
                        if (last_beat) begin
                            word_cnt <= '0;
                            state    <= FILL;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        if (last_beat) begin
                            word_cnt         <= '0;
                            valid_q[req_set] <= 1'b1;
                            dirty_q[req_set] <= 1'b0;
                            // Re-enter LOOKUP so the refilled line is served
                            // by the ordinary hit path.
                            state            <= LOOKUP;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                RESPOND: begin
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request latch and tag store: data only, never reset
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_q  <= bus.req_addr;
            req_we_q    <= bus.req_we;
            req_size_q  <= bus.req_size;
            req_wdata_q <= bus.req_wdata;
        end
        if (fill_done) begin
            tag_q[req_set] <= req_tag;
        end
    end

    assign bus.req_ready        = req_ready_q;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.mem_valid        = mem_valid;
    assign bus.mem_we           = mem_we;
    assign bus.mem_addr         = mem_addr;
    assign bus.mem_wdata        = mem_wdata;
    assign bus.dl_perform_write = dl_perform_write;
    assign bus.dl_set           = dl_set;
    assign bus.dl_op_size       = dl_op_size;
    assign bus.dl_word_select   = dl_word_select;
    assign bus.dl_byte_select   = dl_byte_select;
    assign bus.dl_word_to_store = dl_word_to_store;

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller. Provides a behavioural
// data array, a backing memory whose word at address A is
// (A[7] ? 0xC0 : 0xA0) + A[4:2] with a programmable ack delay, and a beat
// monitor that logs memory traffic and checks stalled beats hold steady.

module tb_cache_controller;
    import cache_controller_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if bus ();

    cache_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int wait_cnt = 0;

    logic [31:0] darray [0:3][0:7];
    logic [31:0] rd_log [$];
    logic [31:0] wr_log_a [$];
    logic [31:0] wr_log_d [$];
    logic        pend = 1'b0;
    logic [31:0] pa;
    logic [31:0] pd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a[7] ? 32'hC0 : 32'hA0) + {29'd0, a[4:2]};
    endfunction

    function automatic logic [31:0] size_mask(input memory_operation_size_e s);
        case (s)
            BYTE:    return 32'h0000_00FF;
            HALF:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input memory_operation_size_e s, input logic [1:0] b);
        logic [31:0] m;
        m = size_mask(s) << {b, 3'b000};
        return (old & ~m) | ((d << {b, 3'b000}) & m);
    endfunction

    // Environment: memory replies and data-array read port
    always_comb begin
        bus.mem_ack         = bus.mem_valid && (wait_cnt >= ack_delay);
        bus.mem_rdata       = mem_word(bus.mem_addr);
        bus.dl_fetched_word = (darray[bus.dl_set][bus.dl_word_select] >> {bus.dl_byte_select, 3'b000})
                              & size_mask(bus.dl_op_size);
    end

    always @(posedge clk) begin
        if (bus.mem_valid && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus.dl_perform_write)
            darray[bus.dl_set][bus.dl_word_select] <=
                merge(darray[bus.dl_set][bus.dl_word_select], bus.dl_word_to_store,
                      bus.dl_op_size, bus.dl_byte_select);
    end

    // Beat monitor: logs acked beats, checks a stalled beat does not move
    always @(negedge clk) begin
        if (reset_n && bus.mem_valid) begin
            if (pend) begin
                chk("beat_addr_stable", bus.mem_addr, pa);
                chk("beat_wdata_stable", bus.mem_wdata, pd);
            end
            if (bus.mem_ack) begin
                if (bus.mem_we) begin
                    wr_log_a.push_back(bus.mem_addr);
                    wr_log_d.push_back(bus.mem_wdata);
                end else begin
                    rd_log.push_back(bus.mem_addr);
                end
                pend = 1'b0;
            end else begin
                pend = 1'b1;
                pa   = bus.mem_addr;
                pd   = bus.mem_wdata;
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input memory_operation_size_e sz,
                         input logic [31:0] wd);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h5A5A_5A5A;
    endtask

    // One full transaction; latency counted in cycles after the accept cycle
    task automatic txn(input string tag, input logic [31:0] a, input logic we,
                       input memory_operation_size_e sz, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rd,
                       input int exp_rds, input int exp_wrs,
                       output int r0, output int w0);
        int lat;
        logic [31:0] rd;
        lat = -1;
        rd  = 32'hDEAD_DEAD;
        r0  = rd_log.size();
        w0  = wr_log_a.size();
        issue(a, we, sz, wd);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = n;
                rd  = bus.resp_rdata;
                break;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        @(negedge clk);
        chk({tag, "_resp_one_cycle"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_mem_reads"}, rd_log.size() - r0, exp_rds);
        chk({tag, "_mem_writes"}, wr_log_a.size() - w0, exp_wrs);
    endtask

    initial begin
        int r0;
        int w0;
        int n;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 8; w++)
                darray[s][w] = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_we    = 1'b0;
        bus.req_size  = WORD;
        bus.req_wdata = '0;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rst_dl_write", {31'd0, bus.dl_perform_write}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

        // Cold miss: fill 0x100..0x11C, answer word 1
        txn("cold_load", 32'h104, 1'b0, WORD, 32'h0, 11, 32'hA1, 8, 0, r0, w0);
        for (int i = 0; i < 8; i++)
            chk("cold_rd_addr", rd_log[r0+i], 32'h100 + 32'(4*i));

        // Hits on the filled line
        txn("hit_byte", 32'h105, 1'b0, BYTE, 32'h0, 2, 32'h0, 0, 0, r0, w0);
        txn("st_half", 32'h106, 1'b1, HALF, 32'hBEEF, 2, 32'h0, 0, 0, r0, w0);
        txn("ld_merged", 32'h104, 1'b0, WORD, 32'h0, 2, 32'hBEEF_00A1, 0, 0, r0, w0);
        txn("ld_half", 32'h106, 1'b0, HALF, 32'h0, 2, 32'h0000_BEEF, 0, 0, r0, w0);

        // Conflict miss on a dirty line: write back then refill
        txn("evict", 32'h184, 1'b0, WORD, 32'h0, 19, 32'hC1, 8, 8, r0, w0);
        for (int i = 0; i < 8; i++) begin
            chk("evict_wr_addr", wr_log_a[w0+i], 32'h100 + 32'(4*i));
            chk("evict_rd_addr", rd_log[r0+i], 32'h180 + 32'(4*i));
        end
        chk("evict_wr_w0", wr_log_d[w0], 32'hA0);
        chk("evict_wr_w1", wr_log_d[w0+1], 32'hBEEF_00A1);
        chk("evict_wr_w7", wr_log_d[w0+7], 32'hA7);

        // Slow memory: each beat waits five cycles for its ack
        ack_delay = 5;
        txn("slow_fill", 32'h204, 1'b0, WORD, 32'h0, 51, 32'hA1, 8, 0, r0, w0);
        for (int i = 0; i < 8; i++)
            chk("slow_rd_addr", rd_log[r0+i], 32'h200 + 32'(4*i));
        txn("st_word", 32'h208, 1'b1, WORD, 32'h1234_5678, 2, 32'h0, 0, 0, r0, w0);
        txn("slow_wb", 32'h104, 1'b0, WORD, 32'h0, 99, 32'hA1, 8, 8, r0, w0);
        for (int i = 0; i < 8; i++)
            chk("slow_wr_addr", wr_log_a[w0+i], 32'h200 + 32'(4*i));
        chk("slow_wr_w1", wr_log_d[w0+1], 32'hA1);
        chk("slow_wr_w2", wr_log_d[w0+2], 32'h1234_5678);
        ack_delay = 0;

        // Reset in the middle of a fill (beat 3 of line 0x380)
        issue(32'h384, 1'b0, WORD, 32'h0);
        n = 0;
        @(negedge clk);
        while (!(bus.mem_valid && bus.mem_addr == 32'h38C) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("fill_beat3_reached", bus.mem_addr, 32'h38C);
        reset_n = 1'b0;
        #1;
        chk("abort_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("abort_dl_write", {31'd0, bus.dl_perform_write}, 32'd0);
        chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("abort_mem_valid_held", {31'd0, bus.mem_valid}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_abort", {31'd0, bus.req_ready}, 32'd1);
        txn("post_reset_miss", 32'h104, 1'b0, WORD, 32'h0, 11, 32'hA1, 8, 0, r0, w0);
        chk("post_reset_rd0", rd_log[r0], 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- XLEN, 32, data and address width
- NUM_SETS, 4, number of cache lines (direct-mapped)
- SET_SIZE, 2, set index width
- WORDS_PER_LINE, 8, words per line
- WORD_SELECT_SIZE, 3, word index width
- BYTE_SELECT_SIZE, 2, byte offset width
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state on posedge
- reset_n, in, 1, asynchronous active-low reset
- req_valid, in, 1, core request valid
- req_ready, out, 1, request accepted when req_valid and req_ready are both high
- req_addr, in, XLEN, byte address
- req_we, in, 1, 1 = store, 0 = load
- req_size, in, memory_operation_size_e, BYTE, HALF or WORD
- req_wdata, in, XLEN, store data, right-aligned
- resp_valid, out, 1, one-cycle response strobe
- resp_rdata, out, XLEN, load data (zero-extended); 0 for stores
- mem_valid, out, 1, backing-memory request
- mem_we, out, 1, memory write
- mem_addr, out, XLEN, word-aligned memory address (low 2 bits = 0)
- mem_wdata, out, XLEN, memory write data
- mem_ack, in, 1, memory completion; ignored while mem_valid = 0
- mem_rdata, in, XLEN, memory read data, valid with mem_ack
- dl_perform_write, out, 1, data-array write enable
- dl_set, out, SET_SIZE, data-array set index
- dl_op_size, out, memory_operation_size_e, data-array access size
- dl_word_select, out, WORD_SELECT_SIZE, data-array word index
- dl_byte_select, out, BYTE_SELECT_SIZE, data-array byte offset
- dl_word_to_store, out, XLEN, data-array write data
- dl_fetched_word, in, XLEN, data-array combinational read data

Function
REQ-003 Address decode SHALL be {tag, set, word, byte} from MSB to LSB; tag width = XLEN-SET_SIZE-WORD_SELECT_SIZE-BYTE_SELECT_SIZE.
REQ-004 The block SHALL hold, per set, a tag register, a valid bit and a dirty bit.
REQ-005 The FSM states SHALL be IDLE, LOOKUP, WRITEBACK, FILL and RESPOND.
REQ-006 req_ready SHALL be 1 only in IDLE; on acceptance the block SHALL latch addr/we/size/wdata and go to LOOKUP.
REQ-007 At most one request SHALL be outstanding; req_* inputs SHALL be ignored outside acceptance.
REQ-008 LOOKUP, hit (valid and tag match):
- dl_set, dl_word_select, dl_byte_select and dl_op_size SHALL be driven from the latched request.
- For a store, dl_perform_write = 1, dl_word_to_store = latched wdata, and the dirty bit is set.
- resp_rdata SHALL be registered from dl_fetched_word for a load, 0 for a store.
- Next state is RESPOND.
REQ-009 LOOKUP, miss: next state SHALL be WRITEBACK if the victim line is valid and dirty, else FILL.
REQ-010 WRITEBACK SHALL issue WORDS_PER_LINE memory writes, words 0..7 in order:
- mem_addr = {victim tag, set, word, 2'b00}; mem_wdata = dl_fetched_word; dl_op_size = WORD.
- The word counter SHALL advance only on mem_ack.
- After the last ack, next state is FILL.
REQ-011 FILL SHALL issue WORDS_PER_LINE memory reads, words 0..7 in order:
- mem_addr = {request tag, set, word, 2'b00}.
- On each mem_ack: dl_perform_write = 1, dl_op_size = WORD, dl_word_to_store = mem_rdata.
- After the last ack: tag <= request tag, valid <= 1, dirty <= 0, next state LOOKUP (which then hits).
REQ-012 mem_valid, mem_we, mem_addr and mem_wdata SHALL remain stable from assertion until the cycle of mem_ack; mem_valid SHALL drop for at least 0 cycles between beats (back-to-back beats allowed).
REQ-013 RESPOND SHALL assert resp_valid for exactly one cycle and return to IDLE.
REQ-014 Hit latency SHALL be: accept in cycle N, resp_valid in cycle N+2.
REQ-015 Miss latency SHALL be N+2 plus 1 cycle per memory beat, plus one additional LOOKUP cycle.
REQ-016 dl_perform_write SHALL be 0 in every state and condition not named above.
REQ-017 Alignment SHALL NOT be checked; byte offset bits SHALL pass to dl_byte_select unchanged.

Reset
REQ-018 While reset_n = 0, state SHALL be IDLE and all valid and dirty bits SHALL be 0.
REQ-019 While reset_n = 0, req_ready = 0, resp_valid = 0, mem_valid = 0, dl_perform_write = 0, and resp_rdata and counters SHALL be 0.
REQ-020 Reset asserted mid-WRITEBACK or mid-FILL SHALL abandon the transfer immediately with no further mem_valid.
REQ-021 Data-array contents SHALL NOT be reset.
REQ-022 req_ready SHALL rise in the first cycle after reset_n deasserts.

Verification
REQ-023 Cold load WORD 0x0000_0104, memory returns word i = 0xA0+i -> 8 mem reads at 0x100..0x11C, resp_rdata = 0xA1, no mem writes.
REQ-024 Then load BYTE 0x0000_0105 -> hit, resp_valid 2 cycles after accept, resp_rdata = 0x0000_0000 (byte 1 of 0xA1).
REQ-025 Store HALF 0xBEEF to 0x0000_0106, then load WORD 0x0000_0104 -> resp_rdata = 0xBEEF_00A1, zero mem traffic.
REQ-026 Load 0x0000_0184 (same set 0, different tag) -> 8 mem writes to 0x100..0x11C with word 1 = 0xBEEF_00A1, then 8 reads from 0x180.
REQ-027 mem_ack delayed 5 cycles per beat -> mem_addr and mem_wdata stable throughout each beat; the counter advances only on ack.
REQ-028 reset_n pulsed low during FILL beat 3 -> mem_valid drops in the same cycle; the next access to that set misses.
